mips_mem_arbiter: RTL

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_mem_arbiter_if.sv | 41 ++++
 rtl/mips_mem_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter_if.sv
// Core-side and bus-side signals of the MIPS memory arbiter.
// The master modport is the arbiter's view; slave is the view of the core plus memory.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction port
  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              inst_stall;
  // data port
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              mem_stall;
  // shared bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
    input  bus_ack, bus_rdata,
    output inst_data, inst_stall, mem_din, mem_stall,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );

  modport slave (
    output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
    output bus_ack, bus_rdata,
    input  inst_data, inst_stall, mem_din, mem_stall,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Two-port (instruction/data) to single-bus memory arbiter with one
// outstanding transaction, optional round-robin on ties and bus timeout.
//
// state  | meaning
// IDLE   | arbitrate; capture winner into bus registers
// BUS    | bus_req held until bus_ack or timeout
// RESP   | one cycle; granted port's stall released
module mips_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  mips_mem_arbiter_if.master  bus
);

  localparam int              CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit              TO_EN  = (TIMEOUT != 0);
  localparam bit              RR_EN  = (PRIO_MODE != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]  inst_data_q, inst_data_d;
  logic [DATA_W-1:0]  mem_din_q, mem_din_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // grant/last: 1 = data port, 0 = instruction port
  logic               grant_q, grant_d;
  logic               last_q, last_d;

  logic               inst_req, data_req, pick_data;
  logic [CNT_W-1:0]   cnt_inc;

  assign inst_req = bus.inst_ren;
  assign data_req = bus.mem_ren | bus.mem_wen;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Stall releases only in the RESP cycle of the port that was granted.
  assign bus.inst_stall = inst_req & ~((state_q == S_RESP) & ~grant_q);
  assign bus.mem_stall  = data_req & ~((state_q == S_RESP) & grant_q);

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.inst_data = inst_data_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.bus_err   = bus_err_q;

  // Next-state, arbitration and bus-register update logic.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    inst_data_d = inst_data_q;
    mem_din_d   = mem_din_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    // On a tie in round-robin mode the port not granted last time wins.
    pick_data   = data_req & (~inst_req | ~RR_EN | ~last_q);

    unique case (state_q)
      S_IDLE: begin
        if (inst_req | data_req) begin
          grant_d    = pick_data;
          last_d     = pick_data;
          bus_req_d  = 1'b1;
          // read+write together is serviced as a plain write
          bus_we_d   = pick_data & bus.mem_wen;
          bus_addr_d = pick_data ? bus.mem_addr : bus.inst_addr;
          if (pick_data) bus_wdata_d = bus.mem_dout;
          cnt_d      = '0;
          state_d    = S_BUS;
        end
      end
      S_BUS: begin
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            if (grant_q) mem_din_d   = bus.bus_rdata;
            else         inst_data_d = bus.bus_rdata;
          end
          state_d = S_RESP;
        end else if (TO_EN && (cnt_inc == TO_VAL)) begin
          // abort: poison the read data so the core sees an obvious value
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) begin
            if (grant_q) mem_din_d   = '1;
            else         inst_data_d = '1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any bus transaction at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      inst_data_q <= '0;
      mem_din_q   <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      inst_data_q <= inst_data_d;
      mem_din_q   <= mem_din_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

endmodule
